// File: rtl/truth_table_pkg.sv
// Shared types and sizing helpers for the truth-table checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam int DEF_N_IN  = 3;
    localparam int DEF_N_OUT = 2;
    localparam int N_VEC     = 2 ** DEF_N_IN;

    // Number of vectors in a full sweep over n_in inputs.
    function automatic int vec_count(input int n_in);
        return 2 ** n_in;
    endfunction

    // Width of a packed truth table: one n_out-bit entry per vector.
    function automatic int table_width(input int n_in, input int n_out);
        return n_out * (2 ** n_in);
    endfunction

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that paces how long each vector is held.
// Latency: load/decrement take effect at the next rising edge.
// Backpressure: none; stops at zero and holds until reloaded.
module settle_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins over decrement; never underflows.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector into a combinational block, captures its outputs and scores them.
// Latency: done pulses in the cycle after edge k + 2**N_IN*SETTLE_CYCLES (start seen at edge k).
// Backpressure: none; start is only honoured in IDLE, results hold until the next start.
module truth_table_checker
    import truth_table_pkg::*;
#(
    parameter int N_IN          = DEF_N_IN,
    parameter int N_OUT         = DEF_N_OUT,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   start,
    output logic [N_IN-1:0]                        vec,
    input  logic [N_OUT-1:0]                       s_in,
    input  logic [table_width(N_IN, N_OUT)-1:0]    expected,
    output logic                                   busy,
    output logic                                   done,
    output logic                                   pass,
    output logic [table_width(N_IN, N_OUT)-1:0]    captured,
    output logic [N_IN:0]                          fail_count,
    output logic [N_IN-1:0]                        first_fail_idx
);

    localparam int NV = vec_count(N_IN);
    localparam int TW = table_width(N_IN, N_OUT);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]   RELOAD   = CW'(SETTLE_CYCLES - 1);
    localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

    state_e            state_q, state_d;
    logic [N_IN-1:0]   vec_q, vec_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [TW-1:0]     captured_q, captured_d;
    logic [N_IN:0]     fail_q, fail_d;
    logic [N_IN-1:0]   ffi_q, ffi_d;
    logic              timer_load;
    logic              timer_dec;
    logic              timer_zero;
    int unsigned       base;

    settle_timer #(
        .W (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (RELOAD),
        .dec      (timer_dec),
        .zero     (timer_zero)
    );

    // Sweep sequencing: start clears results, each timer expiry samples and scores one vector.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        captured_d = captured_q;
        fail_d     = fail_q;
        ffi_d      = ffi_q;
        timer_load = 1'b0;
        timer_dec  = 1'b0;
        base       = 32'(vec_q) * 32'(N_OUT);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    busy_d     = 1'b1;
                    vec_d      = '0;
                    timer_load = 1'b1;
                    captured_d = '0;
                    fail_d     = '0;
                    ffi_d      = '0;
                    pass_d     = 1'b0;
                end
            end
            RUN: begin
                if (!timer_zero) begin
                    timer_dec = 1'b1;
                end else begin
                    captured_d[base +: N_OUT] = s_in;
                    if (s_in != expected[base +: N_OUT]) begin
                        fail_d = fail_q + 1'b1;
                        if (fail_q == '0) begin
                            ffi_d = vec_q;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = FIN;
                        busy_d  = 1'b0;
                        vec_d   = '0;
                        done_d  = 1'b1;
                        pass_d  = (fail_d == '0);
                    end else begin
                        vec_d      = vec_q + 1'b1;
                        timer_load = 1'b1;
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and result registers; reset aborts any sweep without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            captured_q <= '0;
            fail_q     <= '0;
            ffi_q      <= '0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            captured_q <= captured_d;
            fail_q     <= fail_d;
            ffi_q      <= ffi_d;
        end
    end

    assign vec            = vec_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign captured       = captured_q;
    assign fail_count     = fail_q;
    assign first_fail_idx = ffi_q;

endmodule

// File: tb/tb_truth_table_checker.sv
module tb_truth_table_checker;

    localparam logic [15:0] EXP_TABLE = 16'hE994;

    typedef struct {
        logic [15:0] captured;
        logic [3:0]  fail_count;
        logic [2:0]  ffi;
        logic        pass;
    } result_t;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0: SETTLE_CYCLES = 4
    logic        rst_n0, start0, busy0, done0, pass0;
    logic [2:0]  vec0, ffi0;
    logic [1:0]  s_in0;
    logic [15:0] cap0;
    logic [3:0]  fc0;
    logic        stuck_s1;

    // Instance 1: SETTLE_CYCLES = 1
    logic        rst_n1, start1, busy1, done1, pass1;
    logic [2:0]  vec1, ffi1;
    logic [1:0]  s_in1;
    logic [15:0] cap1;
    logic [3:0]  fc1;

    result_t sb_q[$];
    result_t exp_r;

    // Reference combinational block: s1 = a^b^c, s2 = majority(a,b,c).
    function automatic logic [1:0] model_s(input logic [2:0] v, input logic stuck);
        logic s1, s2;
        s1 = stuck ? 1'b0 : (v[2] ^ v[1] ^ v[0]);
        s2 = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
        return {s2, s1};
    endfunction

    // Expected outcome of a complete sweep against EXP_TABLE.
    function automatic result_t model_result(input logic stuck);
        result_t r;
        logic [15:0] et;
        et = EXP_TABLE;
        r.captured = '0;
        r.fail_count = '0;
        r.ffi = '0;
        for (int i = 0; i < 8; i++) begin
            r.captured[i*2 +: 2] = model_s(3'(i), stuck);
            if (r.captured[i*2 +: 2] != et[i*2 +: 2]) begin
                if (r.fail_count == 0) r.ffi = 3'(i);
                r.fail_count = r.fail_count + 1'b1;
            end
        end
        r.pass = (r.fail_count == 0);
        return r;
    endfunction

    always_comb s_in0 = model_s(vec0, stuck_s1);
    always_comb s_in1 = model_s(vec1, 1'b0);

    truth_table_checker #(.N_IN(3), .N_OUT(2), .SETTLE_CYCLES(4)) dut0 (
        .clk(clk), .rst_n(rst_n0), .start(start0), .vec(vec0), .s_in(s_in0),
        .expected(EXP_TABLE), .busy(busy0), .done(done0), .pass(pass0),
        .captured(cap0), .fail_count(fc0), .first_fail_idx(ffi0)
    );

    truth_table_checker #(.N_IN(3), .N_OUT(2), .SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n1), .start(start1), .vec(vec1), .s_in(s_in1),
        .expected(EXP_TABLE), .busy(busy1), .done(done1), .pass(pass1),
        .captured(cap1), .fail_count(fc1), .first_fail_idx(ffi1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start on instance 0 for one edge; returns the edge index it was seen at.
    task automatic pulse0(output int k);
        start0 = 1'b1;
        tick();
        k = cyc;
        start0 = 1'b0;
    endtask

    // Wait (bounded) for done on instance 0; returns the edge index of the done cycle.
    task automatic wait_done0(output int e);
        int n;
        n = 0;
        while (!done0 && n < 400) begin
            tick();
            n++;
        end
        e = cyc;
    endtask

    task automatic test_reset();
        rst_n0 = 1'b0; start0 = 1'b1;
        rst_n1 = 1'b0; start1 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if ({vec0, busy0, done0, pass0, cap0, fc0, ffi0} !== '0) begin
                n_err++;
                $display("FAIL reset0 edge%0d: got vec=%0d busy=%b done=%b pass=%b cap=%h fc=%0d ffi=%0d, need all 0",
                         i, vec0, busy0, done0, pass0, cap0, fc0, ffi0);
            end
            n_vec++;
            if ({vec1, busy1, done1, pass1, cap1, fc1, ffi1} !== '0) begin
                n_err++;
                $display("FAIL reset1 edge%0d: got vec=%0d busy=%b cap=%h, need all 0", i, vec1, busy1, cap1);
            end
        end
        start0 = 1'b0; start1 = 1'b0;
        rst_n0 = 1'b1; rst_n1 = 1'b1;
        tick();
        n_vec++;
        if (busy0 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_start: busy=%b, need 0", busy0);
        end
    endtask

    task automatic test_good_sweep();
        int k, m, e;
        int vec_bad;
        stuck_s1 = 1'b0;
        sb_q.push_back(model_result(1'b0));
        pulse0(k);
        n_vec++;
        if (busy0 !== 1'b1 || vec0 !== 3'd0 || cap0 !== 16'h0 || pass0 !== 1'b0) begin
            n_err++;
            $display("FAIL good_start: busy=%b vec=%0d cap=%h pass=%b, need 1 0 0000 0", busy0, vec0, cap0, pass0);
        end
        vec_bad = 0;
        m = 0;
        while (!done0 && m < 400) begin
            tick();
            m = cyc - k;
            if (m < 32 && vec0 !== 3'(m / 4)) vec_bad++;
        end
        e = cyc;
        n_vec++;
        if (vec_bad != 0) begin
            n_err++;
            $display("FAIL good_vec_steps: %0d cycles with wrong vec, need 0", vec_bad);
        end
        n_vec++;
        if (e - k != 32) begin
            n_err++;
            $display("FAIL good_latency: done %0d edges after start, need 32", e - k);
        end
        n_vec++;
        if (busy0 !== 1'b0 || vec0 !== 3'd0) begin
            n_err++;
            $display("FAIL good_fin: busy=%b vec=%0d, need 0 0", busy0, vec0);
        end
        exp_r = sb_q.pop_front();
        n_vec++;
        if (cap0 !== exp_r.captured || cap0 !== EXP_TABLE || fc0 !== exp_r.fail_count
            || ffi0 !== exp_r.ffi || pass0 !== exp_r.pass) begin
            n_err++;
            $display("FAIL good_result: cap=%h fc=%0d ffi=%0d pass=%b, need %h %0d %0d %b",
                     cap0, fc0, ffi0, pass0, exp_r.captured, exp_r.fail_count, exp_r.ffi, exp_r.pass);
        end
        tick();
        n_vec++;
        if (done0 !== 1'b0) begin
            n_err++;
            $display("FAIL good_done_pulse: done=%b one cycle later, need 0", done0);
        end
        tick(); tick();
        n_vec++;
        if (cap0 !== EXP_TABLE || pass0 !== 1'b1) begin
            n_err++;
            $display("FAIL good_hold: cap=%h pass=%b, need %h 1", cap0, pass0, EXP_TABLE);
        end
    endtask

    task automatic test_stuck_s1();
        int k, e;
        stuck_s1 = 1'b1;
        sb_q.push_back(model_result(1'b1));
        pulse0(k);
        wait_done0(e);
        exp_r = sb_q.pop_front();
        n_vec++;
        if (e - k != 32) begin
            n_err++;
            $display("FAIL stuck_latency: %0d edges, need 32", e - k);
        end
        n_vec++;
        if (cap0 !== exp_r.captured || fc0 !== exp_r.fail_count || ffi0 !== exp_r.ffi || pass0 !== exp_r.pass) begin
            n_err++;
            $display("FAIL stuck_result: cap=%h fc=%0d ffi=%0d pass=%b, need %h %0d %0d %b",
                     cap0, fc0, ffi0, pass0, exp_r.captured, exp_r.fail_count, exp_r.ffi, exp_r.pass);
        end
        n_vec++;
        if (fc0 !== 4'd4 || ffi0 !== 3'd1 || pass0 !== 1'b0) begin
            n_err++;
            $display("FAIL stuck_const: fc=%0d ffi=%0d pass=%b, need 4 1 0", fc0, ffi0, pass0);
        end
        stuck_s1 = 1'b0;
        tick(); tick();
    endtask

    task automatic test_back_to_back();
        int k, e, n, k2, e2;
        sb_q.push_back(model_result(1'b0));
        pulse0(k);
        n = 0;
        while (vec0 !== 3'd3 && n < 100) begin
            tick();
            n++;
        end
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        wait_done0(e);
        exp_r = sb_q.pop_front();
        n_vec++;
        if (e - k != 32) begin
            n_err++;
            $display("FAIL b2b_ignored_start_latency: %0d edges, need 32", e - k);
        end
        n_vec++;
        if (cap0 !== exp_r.captured || pass0 !== exp_r.pass) begin
            n_err++;
            $display("FAIL b2b_first_result: cap=%h pass=%b, need %h %b", cap0, pass0, exp_r.captured, exp_r.pass);
        end
        // Raise start in the cycle after done; it is seen at the first edge in IDLE.
        tick();
        sb_q.push_back(model_result(1'b0));
        pulse0(k2);
        n_vec++;
        if (busy0 !== 1'b1 || cap0 !== 16'h0 || fc0 !== 4'd0 || pass0 !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_cleared: busy=%b cap=%h fc=%0d pass=%b, need 1 0000 0 0", busy0, cap0, fc0, pass0);
        end
        wait_done0(e2);
        exp_r = sb_q.pop_front();
        n_vec++;
        if (e2 - k2 != 32 || cap0 !== exp_r.captured || pass0 !== exp_r.pass) begin
            n_err++;
            $display("FAIL b2b_second: latency=%0d cap=%h pass=%b, need 32 %h %b",
                     e2 - k2, cap0, pass0, exp_r.captured, exp_r.pass);
        end
        tick(); tick();
    endtask

    task automatic test_mid_reset();
        int k, n, saw_done, e;
        pulse0(k);
        n = 0;
        while (vec0 !== 3'd5 && n < 100) begin
            tick();
            n++;
        end
        n_vec++;
        if (vec0 !== 3'd5) begin
            n_err++;
            $display("FAIL midrst_reach: vec=%0d, need 5", vec0);
        end
        rst_n0 = 1'b0;
        tick();
        rst_n0 = 1'b1;
        n_vec++;
        if (vec0 !== 3'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_abort: vec=%0d busy=%b done=%b, need 0 0 0", vec0, busy0, done0);
        end
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done0 === 1'b1 || busy0 === 1'b1) saw_done++;
        end
        n_vec++;
        if (saw_done != 0) begin
            n_err++;
            $display("FAIL midrst_quiet: %0d cycles with done/busy, need 0", saw_done);
        end
        sb_q.push_back(model_result(1'b0));
        pulse0(k);
        wait_done0(e);
        exp_r = sb_q.pop_front();
        n_vec++;
        if (e - k != 32 || cap0 !== exp_r.captured || fc0 !== exp_r.fail_count || pass0 !== exp_r.pass) begin
            n_err++;
            $display("FAIL midrst_resweep: latency=%0d cap=%h fc=%0d pass=%b, need 32 %h %0d %b",
                     e - k, cap0, fc0, pass0, exp_r.captured, exp_r.fail_count, exp_r.pass);
        end
    endtask

    task automatic test_fast_settle();
        int k, m, vec_bad;
        sb_q.push_back(model_result(1'b0));
        start1 = 1'b1;
        tick();
        k = cyc;
        start1 = 1'b0;
        vec_bad = 0;
        m = 0;
        while (!done1 && m < 100) begin
            tick();
            m = cyc - k;
            if (m < 8 && vec1 !== 3'(m)) vec_bad++;
        end
        exp_r = sb_q.pop_front();
        n_vec++;
        if (vec_bad != 0) begin
            n_err++;
            $display("FAIL fast_vec_steps: %0d cycles with wrong vec, need 0", vec_bad);
        end
        n_vec++;
        if (m != 8) begin
            n_err++;
            $display("FAIL fast_latency: done %0d edges after start, need 8", m);
        end
        n_vec++;
        if (cap1 !== exp_r.captured || cap1 !== EXP_TABLE || pass1 !== 1'b1 || fc1 !== 4'd0) begin
            n_err++;
            $display("FAIL fast_result: cap=%h pass=%b fc=%0d, need %h 1 0", cap1, pass1, fc1, EXP_TABLE);
        end
    endtask

    initial begin
        rst_n0 = 1'b0; start0 = 1'b0; stuck_s1 = 1'b0;
        rst_n1 = 1'b0; start1 = 1'b0;
        #2;
        test_reset();
        test_good_sweep();
        test_stuck_s1();
        test_back_to_back();
        test_mid_reset();
        test_fast_settle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
